// File: rtl/dpram_fifo_pkg.sv
// Shared constants for the dual-port-RAM FIFO controller.
// Contents: data/address widths, RAM depth, RAM read latency, widths of the
// RAM occupancy counter and of the level output, almost-full threshold
// (meaningful only when FIFO_ALMOST_FULL_EN is defined).
package dpram_fifo_pkg;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned ADDR_W     = 5;
  localparam int unsigned DEPTH      = 2**ADDR_W;
  localparam int unsigned RAM_RD_LAT = 1;
  localparam int unsigned CNT_W      = ADDR_W + 1;   // ram_count spans 0..DEPTH
  localparam int unsigned LEVEL_W    = ADDR_W + 2;   // level spans 0..DEPTH+2
  localparam int unsigned AF_THRESH  = 28;

  typedef logic [DATA_W-1:0] data_t;

endpackage

// File: rtl/dpram_fifo_outbuf.sv
// Two-entry output buffer fed by RAM read returns.
// Ports:
//   clock, sclr   : clock and synchronous active-high reset
//   push, din     : RAM return data written at the tail
//   pop_req       : consumer ready; a pop happens when valid && pop_req
//   valid         : head register holds an entry
//   occ           : entries held (0..2)
//   head          : head entry, stable while valid && !pop_req
module dpram_fifo_outbuf
  import dpram_fifo_pkg::*;
(
  input  logic       clock,
  input  logic       sclr,
  input  logic       push,
  input  data_t      din,
  input  logic       pop_req,
  output logic       valid,
  output logic [1:0] occ,
  output data_t      head
);

  data_t tail;
  logic  pop;

  assign valid = (occ != 2'd0);
  assign pop   = valid && pop_req;

  always_ff @(posedge clock) begin
    if (sclr) begin
      occ  <= '0;
      head <= '0;
      tail <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) head <= din;
          else             tail <= din;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          head <= tail;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          // Simultaneous pop and return: with one entry the return becomes
          // the new head directly; with two it shifts in behind the tail.
          if (occ == 2'd1) begin
            head <= din;
          end else begin
            head <= tail;
            tail <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/dpram_fifo_ctrl.sv
// FIFO controller sequencing an external 8x32 simple dual-port RAM.
// Pushes become RAM writes; committed entries are prefetched into a
// two-entry output buffer and presented as a valid/ready stream.
// Ports:
//   clock, sclr                  : clock, synchronous active-high reset
//   wr_req, wr_data              : push request and data
//   full, overflow               : RAM full; sticky push-while-full flag
//   out_valid, out_ready, out_data : output stream
//   level                        : ram_count + inflight + buffer occupancy
//   ram_*                        : RAM write/read port controls, ram_q return
//   almost_full                  : only with FIFO_ALMOST_FULL_EN defined
// Optional macro: FIFO_ALMOST_FULL_EN adds almost_full (ram_count >= AF_THRESH).
module dpram_fifo_ctrl
  import dpram_fifo_pkg::*;
(
  input  logic               clock,
  input  logic               sclr,
  input  logic               wr_req,
  input  logic [DATA_W-1:0]  wr_data,
  output logic               full,
  output logic               overflow,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [LEVEL_W-1:0] level,
  output logic [DATA_W-1:0]  ram_data,
  output logic               ram_wren,
  output logic [ADDR_W-1:0]  ram_wraddress,
  output logic [ADDR_W-1:0]  ram_rdaddress,
  output logic               ram_rden,
  output logic               ram_aclr,
  input  logic [DATA_W-1:0]  ram_q
`ifdef FIFO_ALMOST_FULL_EN
  ,
  output logic               almost_full
`endif
);

  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic [CNT_W-1:0]  ram_count;
  logic [CNT_W-1:0]  count_nxt;
  logic              inflight;
  logic              push;
  logic              issue;
  logic              pop;
  logic [1:0]        occ;

  assign full = (ram_count == CNT_W'(DEPTH));
  assign push = wr_req && !full && !sclr;
  assign pop  = out_valid && out_ready;

  // Issue only if the buffer still has room once the pending return lands,
  // counting a same-cycle pop as freeing a slot.
  assign issue = !sclr && (ram_count != '0) &&
                 (({1'b0, occ} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));

  assign count_nxt = ram_count + CNT_W'(push) - CNT_W'(issue);

  assign ram_data      = wr_data;
  assign ram_wren      = push;
  assign ram_wraddress = wptr;
  assign ram_rdaddress = rptr;
  assign ram_rden      = issue;
  assign ram_aclr      = 1'b0;

  assign level = LEVEL_W'(ram_count) + LEVEL_W'(inflight) + LEVEL_W'(occ);

  always_ff @(posedge clock) begin
    if (sclr) begin
      wptr      <= '0;
      rptr      <= '0;
      ram_count <= '0;
      inflight  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (push)  wptr <= wptr + ADDR_W'(1);
      if (issue) rptr <= rptr + ADDR_W'(1);
      if (wr_req && full) overflow <= 1'b1;
      inflight  <= issue;
      ram_count <= count_nxt;
    end
  end

`ifdef FIFO_ALMOST_FULL_EN
  always_ff @(posedge clock) begin
    if (sclr) almost_full <= 1'b0;
    else      almost_full <= (count_nxt >= CNT_W'(AF_THRESH));
  end
`endif

  // inflight is cleared by sclr, so a return arriving after reset is dropped.
  dpram_fifo_outbuf u_outbuf (
    .clock   (clock),
    .sclr    (sclr),
    .push    (inflight),
    .din     (ram_q),
    .pop_req (out_ready),
    .valid   (out_valid),
    .occ     (occ),
    .head    (out_data)
  );

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
module tb_dpram_fifo_ctrl;

  logic       clock;
  logic       sclr;
  logic       wr_req;
  logic [7:0] wr_data;
  logic       full;
  logic       overflow;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [6:0] level;
  logic [7:0] ram_data;
  logic       ram_wren;
  logic [4:0] ram_wraddress;
  logic [4:0] ram_rdaddress;
  logic       ram_rden;
  logic       ram_aclr;
  logic [7:0] ram_q;

  int tests;
  int fails;

  dpram_fifo_ctrl dut (
    .clock         (clock),
    .sclr          (sclr),
    .wr_req        (wr_req),
    .wr_data       (wr_data),
    .full          (full),
    .overflow      (overflow),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .level         (level),
    .ram_data      (ram_data),
    .ram_wren      (ram_wren),
    .ram_wraddress (ram_wraddress),
    .ram_rdaddress (ram_rdaddress),
    .ram_rden      (ram_rden),
    .ram_aclr      (ram_aclr),
    .ram_q         (ram_q)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // External RAM: one-clock read latency; garbage on ram_q when not read.
  logic [7:0] mem [32];
  always @(posedge clock) begin
    if (ram_wren) mem[ram_wraddress] <= ram_data;
    ram_q <= ram_rden ? mem[ram_rdaddress] : 8'($urandom);
  end

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Behavioural model: q holds every stored entry oldest-first, so level is
  // simply its size and the buffer head is q[0]. m_ram/m_fly/m_ob track only
  // where entries sit, to predict full, read issue and out_valid.
  logic [7:0] q[$];
  int m_ram, m_fly, m_ob, m_wp, m_rp, pops;
  bit m_ovf;
  bit started;

  always @(posedge clock) begin
    int p, s, iss;
    if (sclr) begin
      q.delete();
      m_ram = 0; m_fly = 0; m_ob = 0; m_wp = 0; m_rp = 0; m_ovf = 0;
    end else begin
      p   = (m_ob > 0 && out_ready) ? 1 : 0;
      s   = (wr_req && m_ram < 32) ? 1 : 0;
      iss = (m_ram > 0 && (m_ob + m_fly - p) < 2) ? 1 : 0;
      if (wr_req && m_ram == 32) m_ovf = 1;
      if (p != 0) begin
        void'(q.pop_front());
        pops++;
      end
      if (s != 0) q.push_back(wr_data);
      m_ob  = m_ob + m_fly - p;
      m_fly = iss;
      m_ram = m_ram + s - iss;
      m_wp  = (m_wp + s) % 32;
      m_rp  = (m_rp + iss) % 32;
    end
  end

  always @(negedge clock) begin
    int p, iss, wen;
    if (started) begin
      p   = (m_ob > 0 && out_ready) ? 1 : 0;
      iss = (!sclr && m_ram > 0 && (m_ob + m_fly - p) < 2) ? 1 : 0;
      wen = (!sclr && wr_req && m_ram < 32) ? 1 : 0;
      chk("level", level, q.size());
      chk("full", full, (m_ram == 32) ? 1 : 0);
      chk("out_valid", out_valid, (m_ob > 0) ? 1 : 0);
      chk("overflow", overflow, m_ovf);
      if (m_ob > 0 && q.size() > 0) chk("out_data", out_data, q[0]);
      chk("ram_wren", ram_wren, wen);
      chk("ram_rden", ram_rden, iss);
      chk("ram_wraddress", ram_wraddress, m_wp);
      chk("ram_rdaddress", ram_rdaddress, m_rp);
      chk("ram_data", ram_data, wr_data);
      chk("ram_aclr", ram_aclr, 0);
    end
  end

  task automatic cyc(input bit rst, input bit w, input logic [7:0] d, input bit r);
    sclr      = rst;
    wr_req    = w;
    wr_data   = d;
    out_ready = r;
    @(posedge clock);
    #1;
  endtask

  initial begin
    int p0;
    sclr = 1'b1; wr_req = 1'b0; wr_data = '0; out_ready = 1'b0;
    pops = 0; tests = 0; fails = 0; started = 0;
    @(posedge clock); #1;
    cyc(1, 0, 8'h00, 0);
    started = 1;
    chk("rst_level", level, 0);
    chk("rst_full", full, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_overflow", overflow, 0);

    // Basic order and first-output latency.
    cyc(0, 1, 8'h11, 1); chk("lat_c1", out_valid, 0);
    cyc(0, 1, 8'h22, 1); chk("lat_c2", out_valid, 0);
    cyc(0, 1, 8'h33, 1); chk("lat_c3", out_valid, 1); chk("first_11", out_data, 8'h11);
    cyc(0, 0, 8'h00, 1); chk("second_22", out_data, 8'h22);
    cyc(0, 0, 8'h00, 1); chk("third_33", out_data, 8'h33);
    cyc(0, 0, 8'h00, 1); chk("drain_valid", out_valid, 0); chk("drain_level", level, 0);

    // Fill to full and overflow.
    cyc(1, 0, 8'h00, 0);
    for (int i = 0; i < 32; i++) cyc(0, 1, 8'(i + 1), 0);
    chk("fill32_level", level, 32);
    chk("fill32_full", full, 0);
    cyc(0, 1, 8'hA0, 0);
    cyc(0, 1, 8'hA1, 0);
    chk("fill34_level", level, 34);
    chk("fill34_full", full, 1);
    chk("fill34_ovf", overflow, 0);
    cyc(0, 1, 8'hA2, 0);
    chk("ovf_set", overflow, 1);
    chk("ovf_level", level, 34);
    cyc(0, 0, 8'h00, 0);
    chk("ovf_sticky", overflow, 1);
    cyc(1, 0, 8'h00, 0);
    chk("ovf_clear", overflow, 0);

    // Pointer wrap with concurrent pops.
    p0 = pops;
    for (int i = 0; i < 40; i++) cyc(0, 1, 8'(i + 8'h40), 1);
    for (int i = 0; i < 6; i++) cyc(0, 0, 8'h00, 1);
    chk("wrap_pops", pops - p0, 40);
    chk("wrap_level", level, 0);
    chk("wrap_wptr", ram_wraddress, 8);
    chk("wrap_rptr", ram_rdaddress, 8);

    // Streaming: steady one-per-clock with level 3.
    cyc(1, 0, 8'h00, 1);
    for (int i = 0; i < 20; i++) begin
      cyc(0, 1, 8'(8'h80 + i), 1);
      if (i >= 2) begin
        chk("stream_level", level, 3);
        chk("stream_valid", out_valid, 1);
      end
    end
    for (int i = 0; i < 6; i++) cyc(0, 0, 8'h00, 1);

    // Backpressure with out_ready toggling.
    cyc(1, 0, 8'h00, 0);
    for (int i = 0; i < 6; i++) cyc(0, 1, 8'(8'hC0 + i), (i % 2) == 1);
    for (int i = 0; i < 16; i++) cyc(0, 0, 8'h00, (i % 2) == 0);
    chk("bp_level", level, 0);

    // Mid-operation reset with a read in flight.
    cyc(0, 1, 8'hA1, 1);
    cyc(0, 1, 8'hA2, 1);
    cyc(1, 1, 8'hA3, 1);
    chk("mrst_valid", out_valid, 0); chk("mrst_level", level, 0);
    cyc(0, 0, 8'h00, 1);
    chk("mrst_stale_valid", out_valid, 0); chk("mrst_stale_level", level, 0);
    cyc(0, 1, 8'h5A, 0);
    cyc(0, 0, 8'h00, 0);
    cyc(0, 0, 8'h00, 0);
    chk("mrst_valid2", out_valid, 1);
    chk("mrst_data", out_data, 8'h5A);
    cyc(0, 0, 8'h00, 1);
    chk("mrst_final", level, 0);

    started = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dpram_fifo_ctrl.md
Name: dpram_fifo_ctrl

Overview:
- Synchronous FIFO controller that sequences the 8x32 simple dual-port RAM (dpram8x32 instance, external to this block).
- Converts a write-request stream into RAM writes.
- Prefetches RAM reads into a 2-entry output buffer and presents a valid/ready stream.
- Sits between the capture front end and downstream consumers in the 8-bit data path.

Parameters:
- DATA_W, 8, data width; must match the RAM word.
- ADDR_W, 5, RAM address width.
- DEPTH, 32, RAM entries; equals 2**ADDR_W.
- AF_THRESH, 28, almost-full threshold on ram_count. Used only with FIFO_ALMOST_FULL_EN.

Ports:
- clock  in  1  single clock; all logic on its rising edge.
- sclr  in  1  synchronous active-high reset.
- wr_req  in  1  push wr_data this cycle.
- wr_data  in  DATA_W  push data.
- full  out  1  ram_count == DEPTH.
- overflow  out  1  sticky: set by wr_req while full; cleared only by sclr.
- out_valid  out  1  out_data holds the head entry.
- out_ready  in  1  consumer accepts the head entry.
- out_data  out  DATA_W  head entry.
- level  out  ADDR_W+2  total entries held: ram_count + inflight + out buffer occupancy; range 0..DEPTH+2.
- ram_data  out  DATA_W  write data to RAM; equals wr_data.
- ram_wren  out  1  RAM write enable.
- ram_wraddress  out  ADDR_W  RAM write address; equals wptr.
- ram_rdaddress  out  ADDR_W  RAM read address; equals rptr.
- ram_rden  out  1  RAM read enable.
- ram_aclr  out  1  tied 0.
- ram_q  in  DATA_W  RAM read data, valid exactly 1 clock after ram_rden.

Behaviour:
- Reset (sclr=1 at edge): wptr, rptr, ram_count, inflight, out buffer occupancy, overflow all 0.
  - Outputs after reset: full=0, out_valid=0, out_data=0, level=0, ram_wren=0, ram_rden=0.
  - ram_q returning in the cycle after a mid-operation reset is discarded.
  - A push or pop on a reset cycle is ignored.
- Push:
  - Accepted when wr_req && !full. Drives ram_wren=1 combinationally with ram_wraddress=wptr.
  - wptr increments mod DEPTH (natural 5-bit wrap 31->0).
  - Push while full: RAM is not written, overflow is set, state is otherwise unchanged.
- Read issue: ram_rden=1 when ram_count>0 && (out_occ + inflight - pop) < 2, where pop = out_valid && out_ready.
  - On issue: rptr increments mod DEPTH and inflight <= 1.
  - At most one read is in flight.
- Return: while inflight=1, the next cycle writes ram_q into the out buffer tail; inflight then clears unless a new read is issued that cycle.
- ram_count update: +push -issue in the same cycle. Simultaneous push and issue leave it unchanged.
- Address hazard: read and write never target the same address in one cycle, because reads only target committed entries.
- Out buffer:
  - 2-entry FIFO; out_valid = (out_occ > 0); out_data is the head register. Head is held stable while out_valid && !out_ready.
  - Pop and return in the same cycle are both honoured.
- Throughput: sustained 1 entry/clock when out_ready is held high.
- Latency: push to out_valid is 3 clocks when empty (write, read issue, return).
- level and full are registered-state derived; they update the cycle after the event.

Optional Feature:
- Macro FIFO_ALMOST_FULL_EN.
  - Defined: adds output almost_full (1 bit) = (ram_count >= AF_THRESH), registered, reset 0.
  - Undefined: port and logic absent; AF_THRESH unused.

Decomposition:
- Package dpram_fifo_pkg: DATA_W, ADDR_W, DEPTH, RAM_RD_LAT=1, and level width constant.
- One sub-module, dpram_fifo_outbuf: 2-entry output buffer with push (return), pop, occupancy, head data.
- Pointer, count, and issue logic stay in the top level.

Test Plan:
- Reset, then push 0x11,0x22,0x33 with out_ready=1 -> out_data 0x11,0x22,0x33 in order; first out_valid 3 clocks after first push; level returns to 0.
- Push 32 entries with out_ready=0 -> out buffer takes 2, ram_count=30, level=32, full=0. Push 2 more -> full=1, level=34. 35th push -> overflow=1, level stays 34.
- Pointer wrap: 40 pushes interleaved with pops (out_ready=1) -> data matches the push sequence across the 31->0 address wrap; ram_wraddress and ram_rdaddress wrap correctly.
- Streaming: continuous wr_req with out_ready=1 from cycle 3 -> exactly one out_valid&&out_ready per clock; level constant at 3.
- Backpressure: toggle out_ready 1010... while a read is in flight -> no data lost or duplicated; out_data stable while stalled.
- Mid-operation sclr with inflight=1 -> following cycle out_valid=0 and level=0; stale ram_q ignored; first post-reset push is read back correctly.
